// File: rtl/alu_mc.sv
// ============================================================================
// Module   : alu_mc
// Brief    : Multi-cycle MIPS ALU with a valid/ready handshake on both sides
//            and registered results.
//            Single-cycle ops: AND, OR, ADD, NOR, SUB, SLT.
//            Iterative ops: MULU (shift-add) and DIVU (restoring division),
//            which return a HI/LO result pair.
//            Build option ALU_MULDIV_EN compiles in the MULU/DIVU datapath.
//            Without it, ops 3 and 4 complete in one cycle and flag err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf,
  output logic             dz,
  output logic             err
);

  localparam logic [2:0] c_OP_AND  = 3'd0;
  localparam logic [2:0] c_OP_OR   = 3'd1;
  localparam logic [2:0] c_OP_ADD  = 3'd2;
  localparam logic [2:0] c_OP_MULU = 3'd3;
  localparam logic [2:0] c_OP_DIVU = 3'd4;
  localparam logic [2:0] c_OP_NOR  = 3'd5;
  localparam logic [2:0] c_OP_SUB  = 3'd6;
  localparam logic [2:0] c_OP_SLT  = 3'd7;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t r_state;

  logic             w_accept;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic             w_ovf;
  logic             w_dz;
  logic             w_err;

  // The consumer draining DONE frees the block for a back-to-back accept.
  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;

  assign w_sum  = a + b;
  assign w_diff = a - b;

  // Single-cycle result and flags, computed from the operands being accepted.
  always_comb begin
    w_lo  = '0;
    w_hi  = '0;
    w_ovf = 1'b0;
    w_dz  = 1'b0;
    w_err = 1'b0;
    case (op)
      c_OP_AND: w_lo = a & b;
      c_OP_OR:  w_lo = a | b;
      c_OP_ADD: begin
        w_lo  = w_sum;
        w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      c_OP_NOR: w_lo = ~(a | b);
      c_OP_SUB: begin
        w_lo  = w_diff;
        w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      c_OP_SLT: w_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_MULDIV_EN
      // Only divide-by-zero finishes in one cycle; the rest go through BUSY.
      c_OP_DIVU: begin
        if (b == '0) begin
          w_lo = '1;
          w_hi = a;
          w_dz = 1'b1;
        end
      end
`else
      c_OP_MULU, c_OP_DIVU: w_err = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int c_CNT_W = $clog2(WIDTH + 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic               r_is_div;
  logic [WIDTH-1:0]   r_whi;
  logic [WIDTH-1:0]   r_wlo;

  logic               w_start_busy;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;

  assign w_start_busy = (op == c_OP_MULU) || ((op == c_OP_DIVU) && (b != '0));

  // One iteration of shift-add multiply or restoring divide on {r_whi, r_wlo}.
  // Multiply: r_wlo starts as the multiplier and fills with product bits.
  // Divide:   r_wlo starts as the dividend and fills with quotient bits,
  //           r_whi holds the partial remainder. The top bit of the trial
  //           subtraction is its borrow, since the remainder is always < 2*b.
  always_comb begin
    w_mul_sum  = {1'b0, r_whi} + (r_wlo[0] ? {1'b0, r_opa} : '0);
    w_div_sh   = {r_whi, r_wlo[WIDTH-1]};
    w_div_diff = w_div_sh - {1'b0, r_opb};
    w_div_ge   = ~w_div_diff[WIDTH];
    if (r_is_div) begin
      w_step_hi = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
      w_step_lo = {r_wlo[WIDTH-2:0], w_div_ge};
    end else begin
      w_step_hi = w_mul_sum[WIDTH:1];
      w_step_lo = {w_mul_sum[0], r_wlo[WIDTH-1:1]};
    end
  end

  // Iterative datapath registers: counter, captured operands and work pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_whi    <= '0;
      r_wlo    <= '0;
    end else if (w_accept && w_start_busy) begin
      r_cnt    <= c_CNT_W'(WIDTH);
      r_opa    <= a;
      r_opb    <= b;
      r_is_div <= (op == c_OP_DIVU);
      r_whi    <= '0;
      r_wlo    <= (op == c_OP_DIVU) ? a : b;
    end else if (r_state == S_BUSY) begin
      r_cnt    <= r_cnt - 1'b1;
      r_whi    <= w_step_hi;
      r_wlo    <= w_step_lo;
    end
  end
`endif

  // Control FSM and the held result/flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      result_lo <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
      err       <= 1'b0;
    end else if (w_accept) begin
`ifdef ALU_MULDIV_EN
      if (w_start_busy) begin
        r_state <= S_BUSY;
      end else begin
`endif
        r_state   <= S_DONE;
        result_lo <= w_lo;
        result_hi <= w_hi;
        zero      <= (w_lo == '0);
        ovf       <= w_ovf;
        dz        <= w_dz;
        err       <= w_err;
`ifdef ALU_MULDIV_EN
      end
`endif
    end else begin
      case (r_state)
`ifdef ALU_MULDIV_EN
        S_BUSY: begin
          // The edge that takes the counter from 1 to 0 lands the result.
          if (r_cnt == c_CNT_W'(1)) begin
            r_state   <= S_DONE;
            result_lo <= w_step_lo;
            result_hi <= w_step_hi;
            zero      <= (w_step_lo == '0);
            ovf       <= 1'b0;
            dz        <= 1'b0;
            err       <= 1'b0;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
// Module   : tb_alu_mc
// Brief    : Self-checking bench for alu_mc. Directed cases, back-to-back
//            streaming, reset during an operation and random ops, all
//            compared against an arithmetic reference model.
//            Expectations follow the ALU_MULDIV_EN build option.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mc;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             ovf;
  logic             dz;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        o;
    logic        d;
    logic        e;
    logic [7:0]  lat;
  } exp_t;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .zero      (zero),
    .ovf       (ovf),
    .dz        (dz),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t   r;
    longint s;
    longint c_max;
    longint c_min;
    logic [63:0] p;
    r     = '0;
    r.lat = 8'd1;
    c_max = 64'sd2147483647;
    c_min = -c_max - 1;
    case (o)
      3'd0: r.lo = x & y;
      3'd1: r.lo = x | y;
      3'd2: begin
        s    = longint'($signed(x)) + longint'($signed(y));
        r.lo = s[31:0];
        r.o  = (s > c_max) || (s < c_min);
      end
      3'd3: begin
`ifdef ALU_MULDIV_EN
        p     = {32'd0, x} * {32'd0, y};
        r.lo  = p[31:0];
        r.hi  = p[63:32];
        r.lat = 8'd32;
`else
        p   = '0;
        r.e = 1'b1;
`endif
      end
      3'd4: begin
`ifdef ALU_MULDIV_EN
        if (y == 32'd0) begin
          r.lo = 32'hFFFF_FFFF;
          r.hi = x;
          r.d  = 1'b1;
        end else begin
          r.lo  = x / y;
          r.hi  = x % y;
          r.lat = 8'd32;
        end
`else
        r.e = 1'b1;
`endif
      end
      3'd5: r.lo = ~(x | y);
      3'd6: begin
        s    = longint'($signed(x)) - longint'($signed(y));
        r.lo = s[31:0];
        r.o  = (s > c_max) || (s < c_min);
      end
      default: r.lo = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
    endcase
    r.z = (r.lo == 32'd0);
    return r;
  endfunction

  task automatic check_out(input string pfx, input exp_t e);
    check({pfx, "_lo"},   result_lo, e.lo);
    check({pfx, "_hi"},   result_hi, e.hi);
    check({pfx, "_zero"}, zero,      e.z);
    check({pfx, "_ovf"},  ovf,       e.o);
    check({pfx, "_dz"},   dz,        e.d);
    check({pfx, "_err"},  err,       e.e);
  endtask

  // One transaction from IDLE: accept, wait for the result, optionally
  // hold off the consumer for 'hold' cycles, then drain back to IDLE.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int hold);
    exp_t e;
    int   cyc;
    logic busy_rdy;
    e = model(o, x, y);
    check("start_rdy", in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    cyc = 1;
    busy_rdy = 1'b0;
    while (!out_valid && cyc < 200) begin
      if (in_ready) busy_rdy = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, e.lat);
    check("busy_rdy", busy_rdy, 0);
    check_out("res", e);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_vld", out_valid, 1);
      check("hold_rdy", in_ready, 0);
      check_out("hold", e);
    end
    out_ready = 1'b1;
    #1;
    check("drain_rdy", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_vld", out_valid, 0);
    check("idle_rdy", in_ready, 1);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_rdy"},  in_ready,  1);
    check({pfx, "_vld"},  out_valid, 0);
    check({pfx, "_lo"},   result_lo, 0);
    check({pfx, "_hi"},   result_hi, 0);
    check({pfx, "_zero"}, zero,      0);
    check({pfx, "_ovf"},  ovf,       0);
    check({pfx, "_dz"},   dz,        0);
    check({pfx, "_err"},  err,       0);
  endtask

  logic [2:0]  bo [6];
  logic [31:0] ba [6];
  logic [31:0] bb [6];

  initial begin
    exp_t e;
    logic [2:0] ro;
    logic [31:0] ra, rb;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(3'd2, 32'h7FFF_FFFF, 32'd1, 0);
    run_op(3'd6, 32'd5, 32'd5, 0);
    run_op(3'd7, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(3'd6, 32'h8000_0000, 32'd1, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'd100, 32'd7, 0);
    run_op(3'd4, 32'd9, 32'd0, 0);
    run_op(3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5);
    run_op(3'd3, 32'h0001_2345, 32'h0000_0100, 5);

    // Back-to-back single-cycle ops with both handshakes held high
    bo[0] = 3'd0; bo[1] = 3'd1; bo[2] = 3'd5;
    bo[3] = 3'd2; bo[4] = 3'd6; bo[5] = 3'd7;
    for (int i = 0; i < 6; i++) begin
      ba[i] = $urandom;
      bb[i] = $urandom;
    end
    op = bo[0]; a = ba[0]; b = bb[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      e = model(bo[i], ba[i], bb[i]);
      check("b2b_vld", out_valid, 1);
      check("b2b_lo", result_lo, e.lo);
      check("b2b_ovf", ovf, e.o);
      if (i < 5) begin
        op = bo[i+1]; a = ba[i+1]; b = bb[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_end_vld", out_valid, 0);

    // Reset while a MULU is in flight (BUSY cycle 10)
    op = 3'd3; a = $urandom | 32'd1; b = $urandom | 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_state("arst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_reset_state("arst_rel");
    @(posedge clk); #1;
    check_reset_state("arst_post");

    // Random ops
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised ALU for the MIPS datapath. It supersedes the single-cycle combinational ALU. It keeps the 3-bit ALU control encoding and the zero flag, and adds the following:
- registered outputs;
- a valid/ready handshake on both sides;
- signed overflow and SLT;
- iterative unsigned multiply and divide with a HI/LO result pair.

It sits between the register-file/immediate mux and the writeback stage. The EX stage stalls on `in_ready`.

## Interface
- `WIDTH`, 32: operand and result width, must be ≥ 4.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands and op are valid.
- `in_ready` output 1: block accepts an operation this cycle.
- `op` input 3: 0 AND, 1 OR, 2 ADD, 3 MULU, 4 DIVU, 5 NOR, 6 SUB, 7 SLT.
- `a` input WIDTH: operand A (read_data_1).
- `b` input WIDTH: operand B (read data 2 or immediate).
- `out_valid` output 1: result registers hold a completed result.
- `out_ready` input 1: consumer takes the result.
- `result_lo` output WIDTH: primary result; product low half; quotient.
- `result_hi` output WIDTH: 0 for single-cycle ops; product high half; remainder.
- `zero` output 1: `result_lo == 0`.
- `ovf` output 1: signed overflow, ADD/SUB only, else 0.
- `dz` output 1: DIVU with `b == 0`.
- `err` output 1: unsupported op (see Configuration).

## Operation
- State machine has three states: IDLE, BUSY, DONE.
- Accept = `in_valid && in_ready`. `in_ready = (state==IDLE) || (state==DONE && out_ready)`. `a`, `b` and `op` are captured on accept; later input changes are ignored.
- **Single-cycle ops (0,1,2,5,6,7).**
  - The result is computed from the captured inputs and registered at the accept edge; next state is DONE.
  - ADD/SUB wrap modulo 2^WIDTH.
  - `ovf` = operand signs equal (ADD) or different (SUB), and the result sign differs from A.
  - SLT: `result_lo = {0…, $signed(a) < $signed(b)}`.
- **MULU.**
  - Shift-add, one bit per cycle, over WIDTH BUSY cycles; the counter is loaded with WIDTH on accept.
  - Yields the 2·WIDTH unsigned product as `{result_hi, result_lo}`.
- **DIVU.**
  - Restoring division, one quotient bit per cycle, over WIDTH BUSY cycles.
  - `result_lo` = quotient, `result_hi` = remainder.
  - If `b == 0`: no iteration; go to DONE next edge with `result_lo` = all ones, `result_hi = a`, `dz=1`.
- **BUSY state.**
  - Counter decrements each edge. The edge where it reaches 0 writes the final results and goes to DONE.
  - `in_ready=0` throughout.
- **DONE state.**
  - `out_valid=1`. Results and flags are held stable until `out_ready`.
  - If `out_ready` and no accept in the same cycle: go to IDLE, `out_valid` clears.
  - If `out_ready` and an accept in the same cycle: the new op starts (back-to-back), with the same rules as an accept from IDLE.
- `zero`, `ovf`, `dz` and `err` describe the held result only. Each is updated with that result.
- **Reset.**
  - Reset mid-operation (any state) aborts the operation.
  - State goes to IDLE; counter and operand registers are cleared.

## Timing
- Reset values: `in_ready=1` (IDLE). `out_valid`, `result_lo`, `result_hi`, `zero`, `ovf`, `dz` and `err` are all 0.
- Single-cycle ops: accept at edge E gives `out_valid=1` after E. Latency 1, throughput 1/cycle when `out_ready` is held high.
- MULU/DIVU: accept at edge E gives `out_valid=1` after edge E+WIDTH (32 cycles at default). `in_ready=0` from E until DONE.
- DIVU by zero: latency 1.
- No combinational path from `in_*` to `out_*`. `in_ready` depends combinationally on `out_ready`.

## Configuration
- `ALU_MULDIV_EN` defined: MULU and DIVU are implemented as above.
- `ALU_MULDIV_EN` undefined:
  - Multiply/divide datapath and BUSY state are not compiled.
  - Op 3 or 4 completes in 1 cycle with `result_lo=0`, `result_hi=0`, `zero=1`, `err=1`.
  - `err` is constant 0 for all other ops in both builds.

## Test plan
- Reset mid-MULU (`reset_n` low for 1 cycle at BUSY cycle 10) → IDLE, `in_ready=1`, `out_valid=0`, all results 0.
- ADD `a=32'h7FFFFFFF`, `b=1` with `out_ready=1` → 1 cycle later `result_lo=32'h80000000`, `ovf=1`, `zero=0`. SUB 5−5 → `result_lo=0`, `zero=1`, `ovf=0`.
- SLT `a=32'hFFFFFFFF` (−1), `b=1` → `result_lo=1`. Back-to-back AND, OR, NOR with `in_valid`/`out_ready` held high → one result per cycle, in order.
- MULU `a=32'hFFFFFFFF`, `b=32'hFFFFFFFF` → after exactly 32 cycles `result_hi=32'hFFFFFFFE`, `result_lo=1`. `in_ready=0` meanwhile.
- DIVU `a=100`, `b=7` → after 32 cycles quotient 14, remainder 2. DIVU `a=9`, `b=0` → after 1 cycle `result_lo=32'hFFFFFFFF`, `result_hi=9`, `dz=1`.
- Backpressure: `out_ready=0` for 5 cycles after completion → outputs stable, `in_ready=0`. Build without `ALU_MULDIV_EN`: op 3 → 1 cycle, `err=1`, `result_lo=0`.
